// File: rtl/store_merge_unit.sv
// Store-path narrowing unit: word stores write straight through; byte and halfword
// stores read the target word, merge the narrowed lanes and write the word back.
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Wdata,
  input  logic [1:0]        Size,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRe,
  input  logic [31:0]       MemRdata,
  output logic              MemWe,
  output logic [31:0]       MemWdata
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;   // only the low half is ever merged; words bypass to merge_q
  logic [1:0]        size_q;
  logic [31:0]       merge_q;
  logic [31:0]       merged;
  logic              accept;
  logic              word_ok;
  logic              narrow_ok;

  assign accept    = (state == IDLE) && Start;
  assign word_ok   = (Size == SIZE_WORD) && (Addr[1:0] == 2'b00);
  assign narrow_ok = (Size == SIZE_BYTE) || ((Size == SIZE_HALF) && !Addr[0]);

  // NOTE: asynchronous reset in the sensitivity list, and <= for every register so all
  // state updates see the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (word_ok)        state_nxt = WRITE;
          else if (narrow_ok) state_nxt = READ;
          else                state_nxt = ERROR;
        end
      end
      READ:    state_nxt = MERGE;
      MERGE:   state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane replacement over the word returned by the RAM.
  always_comb begin
    merged = MemRdata;
    case (size_q)
      SIZE_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SIZE_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      default:   merged = MemRdata;
    endcase
  end

  // Operands only load on acceptance, so they hold steady for the whole operation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      merge_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= Addr;
        wdata_q <= Wdata[15:0];
        size_q  <= Size;
        if (word_ok) merge_q <= Wdata;
      end
      if (state == MERGE) merge_q <= merged;
    end
  end

  assign Busy     = (state != IDLE);
  assign MemRe    = (state == READ);
  assign MemWe    = (state == WRITE);
  assign Done     = (state == WRITE);
  assign Err      = (state == ERROR);
  assign MemAddr  = (state == IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign MemWdata = merge_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboarded bench for store_merge_unit: directed stores against a small synchronous
// RAM model; a negedge monitor matches every write/error pulse against the queue.
module tb_store_merge_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic [1:0]  Size;
  logic        Busy, Done, Err, MemRe, MemWe;
  logic [31:0] MemAddr, MemRdata, MemWdata;

  store_merge_unit #(.ADDR_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Addr(Addr), .Wdata(Wdata), .Size(Size),
    .Busy(Busy), .Done(Done), .Err(Err), .MemAddr(MemAddr), .MemRe(MemRe),
    .MemRdata(MemRdata), .MemWe(MemWe), .MemWdata(MemWdata)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rd_count = 0;
  int   last_rd_cyc = -1;

  // Synchronous RAM model, 64 words; preload goes through the same clocked process.
  logic [31:0] mem [0:63];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (MemRe) MemRdata <= mem[MemAddr[7:2]];
    if (MemWe) mem[MemAddr[7:2]] <= MemWdata;
    else if (ld_en) mem[ld_idx] <= ld_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write or error pulse must match the head of the scoreboard.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (MemRe) begin
        rd_count++;
        last_rd_cyc = cyc;
      end
      if (MemWe || Err) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {30'b0, MemWe, Err}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("event_kind_err", {31'b0, Err}, {31'b0, e.is_err});
          check("event_cycle", cyc, e.cyc);
          check("event_addr", MemAddr, e.addr);
          check("exclusive_re", {31'b0, MemRe}, 32'h0);
          if (e.is_err) begin
            check("err_no_done", {31'b0, Done}, 32'h0);
            check("err_no_we", {31'b0, MemWe}, 32'h0);
          end else begin
            check("write_data", MemWdata, e.data);
            check("done_with_we", {31'b0, Done}, 32'h1);
          end
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    ld_en = 1'b1; ld_idx = a[7:2]; ld_data = d;
    @(negedge Clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || Busy) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check({"wait_", tag}, {31'b0, (n >= 40)}, 32'h0);
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    Start = 1'b1; Addr = a; Wdata = d; Size = sz;
    @(negedge Clk);
    Start = 1'b0; Addr = '0; Wdata = '0; Size = '0;
  endtask

  // One store with its hand-computed result; lat is the cycle of Done/Err after Start.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic is_err, input logic [31:0] exp_data,
                        input int lat, input int exp_reads);
    int c, r0;
    @(negedge Clk);
    c  = cyc;
    r0 = rd_count;
    sb.push_back('{is_err: is_err, addr: a & 32'hFFFF_FFFC, data: exp_data, cyc: c + lat});
    drive_start(a, d, sz);
    wait_idle(tag);
    check({tag, "_reads"}, rd_count - r0, exp_reads);
    if (exp_reads > 0) check({tag, "_read_cycle"}, last_rd_cyc, c + 1);
    check({tag, "_idle_addr"}, MemAddr, 32'h0);
  endtask

  initial begin
    int c;
    Reset = 1'b1; Start = 1'b0; Addr = '0; Wdata = '0; Size = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_strobes", {28'b0, Done, Err, MemRe, MemWe}, 32'h0);
    check("rst_memaddr", MemAddr, 32'h0);
    check("rst_memwdata", MemWdata, 32'h0);
    Reset = 1'b0;

    run_op("word", 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'hDEAD_BEEF, 1, 0);

    preload(32'h20, 32'h1122_3344);
    run_op("byte_l2", 32'h22, 32'hFFFF_FFAB, 2'b00, 1'b0, 32'h11AB_3344, 3, 1);
    preload(32'h20, 32'h1122_3344);
    run_op("byte_l0", 32'h20, 32'h0000_0077, 2'b00, 1'b0, 32'h1122_3377, 3, 1);
    preload(32'h20, 32'h1122_3344);
    run_op("byte_l1", 32'h21, 32'h0000_00EE, 2'b00, 1'b0, 32'h1122_EE44, 3, 1);
    preload(32'h20, 32'h1122_3344);
    run_op("half_hi", 32'h22, 32'h0000_CAFE, 2'b01, 1'b0, 32'hCAFE_3344, 3, 1);
    preload(32'h20, 32'h1122_3344);
    run_op("half_lo", 32'h20, 32'h0000_CAFE, 2'b01, 1'b0, 32'h1122_CAFE, 3, 1);

    run_op("err_half", 32'h21, 32'h1234_5678, 2'b01, 1'b1, 32'h0, 1, 0);
    run_op("err_word", 32'h22, 32'h1234_5678, 2'b10, 1'b1, 32'h0, 1, 0);
    run_op("err_size", 32'h24, 32'h1234_5678, 2'b11, 1'b1, 32'h0, 1, 0);

    // Reset in MERGE of a byte store: nothing is pushed, so any write is unexpected.
    preload(32'h20, 32'h1122_3344);
    @(negedge Clk);
    drive_start(32'h21, 32'h0000_0099, 2'b00);
    @(negedge Clk);
    check("pre_reset_busy", {31'b0, Busy}, 32'h1);
    #2 Reset = 1'b1;
    #1;
    check("reset_busy_drop", {31'b0, Busy}, 32'h0);
    check("reset_we_drop", {30'b0, MemWe, MemRe}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    check("no_partial_write", mem[8], 32'h1122_3344);
    run_op("word_after_rst", 32'h20, 32'hA5A5_A5A5, 2'b10, 1'b0, 32'hA5A5_A5A5, 1, 0);

    // Second Start during READ, with different operands, must be ignored.
    preload(32'h20, 32'h1122_3344);
    @(negedge Clk);
    c = cyc;
    sb.push_back('{is_err: 1'b0, addr: 32'h20, data: 32'h5522_3344, cyc: c + 3});
    drive_start(32'h23, 32'h0000_0055, 2'b00);
    check("in_read", {31'b0, MemRe}, 32'h1);
    drive_start(32'h10, 32'h1234_5678, 2'b10);
    wait_idle("start_in_read");
    check("no_extra_op", {31'b0, Busy}, 32'h0);

    repeat (3) @(negedge Clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
